// File: rtl/input_compare_if.sv
// input_compare_if: player switch inputs and round result bundle for the compare stage
interface input_compare_if;
  logic       start;
  logic [1:0] testcase;
  logic [9:0] sw;
  logic [1:0] score;
  logic       compare_finish;
  logic       busy;
  logic [3:0] idx;
  modport master(output start, testcase, sw, input score, compare_finish, busy, idx);
  modport slave(input start, testcase, sw, output score, compare_finish, busy, idx);
endinterface

// File: rtl/input_compare.sv
// input_compare: captures player switch entries, checks them against the displayed sequence, scores the round
module input_compare #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TW = 16
) (
  input logic clk,
  input logic reset_n,
  input_compare_if.slave io
);
  typedef enum logic [1:0] {IDLE, WAIT_IN, CHECK, DONE} state_t;
  localparam logic [3:0] S1 [8] = '{4'd1, 4'd9, 4'd4, 4'd2, 4'd0, 4'd8, 4'd7, 4'd5};
  localparam logic [3:0] S2 [8] = '{4'd0, 4'd4, 4'd1, 4'd3, 4'd2, 4'd0, 4'd0, 4'd0};
  localparam logic [3:0] S3 [8] = '{4'd9, 4'd2, 4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
  state_t state, state_n;
  logic [1:0] tc, mis, mis_n, score_q;
  logic [3:0] idx_q, exp_d, len, digit;
  logic [TW-1:0] timer;
  logic [9:0] s1, s2, sp, rise;
  logic hit, press, valid, tout, accept;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
      sp <= '0;
      rise <= '0;
    end else begin
      s1 <= io.sw;
      s2 <= s1;
      sp <= s2;
      rise <= s2 & ~sp;
    end
  always_comb begin
    digit = '0;
    for (int i = 0; i < 10; i++) if (rise[i]) digit = 4'(i);
  end
  assign press = |rise;
  assign valid = press && ((rise & (rise - 10'd1)) == '0);
  assign exp_d = tc == 2'd3 ? S3[idx_q[2:0]] : tc == 2'd2 ? S2[idx_q[2:0]] : S1[idx_q[2:0]];
  assign len = tc == 2'd3 ? 4'd3 : tc == 2'd2 ? 4'd5 : 4'd8;
  assign tout = timer == TW'(TIMEOUT_CYCLES - 1);
  assign mis_n = hit ? mis : mis == 2'd3 ? 2'd3 : mis + 2'd1;
  assign accept = io.start && io.testcase != 2'd0;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = accept ? WAIT_IN : IDLE;
      WAIT_IN: state_n = press || tout ? CHECK : WAIT_IN;
      CHECK:   state_n = idx_q + 4'd1 == len || mis_n == 2'd3 ? DONE : WAIT_IN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      tc <= '0;
      mis <= '0;
      idx_q <= '0;
      timer <= '0;
      hit <= 1'b0;
      score_q <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          tc <= io.testcase;
          idx_q <= '0;
          mis <= '0;
          timer <= '0;
        end
        WAIT_IN: begin
          timer <= timer + 1'b1;
          if (press) hit <= valid && digit == exp_d;
          else if (tout) hit <= 1'b0;
        end
        CHECK: begin
          mis <= mis_n;
          idx_q <= idx_q + 4'd1;
          timer <= '0;
        end
        default: score_q <= 2'd3 - mis;
      endcase
    end
  assign io.score = score_q;
  assign io.idx = idx_q;
  assign io.busy = state != IDLE;
  assign io.compare_finish = state == DONE;
endmodule

// File: tb/tb_input_compare.sv
// tb_input_compare: directed scenario checks of the player input compare stage
module tb_input_compare;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int pass_cnt = 0;
  int total = 0;
  int fin_cnt = 0;
  always #5 clk = ~clk;
  input_compare_if bus();
  input_compare #(.TIMEOUT_CYCLES(8), .TW(16)) dut (.clk(clk), .reset_n(reset_n), .io(bus));
  always @(negedge clk) if (bus.compare_finish === 1'b1) fin_cnt++;

  task start_round(input logic [1:0] t);
    @(negedge clk);
    bus.start = 1'b1;
    bus.testcase = t;
    @(negedge clk);
    bus.start = 1'b0;
    total++;
    if (bus.busy !== 1'b1) $display("FAIL start_busy: got %b expected 1", bus.busy);
    else pass_cnt++;
  endtask

  task press(input logic [9:0] m);
    logic [3:0] old;
    int n;
    old = bus.idx;
    bus.sw = m;
    n = 0;
    while (bus.idx === old && n < 12) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bus.idx !== old + 4'd1) $display("FAIL press_idx %h: got %0d expected %0d", m, bus.idx, old + 4'd1);
    else pass_cnt++;
    bus.sw = '0;
    @(negedge clk);
  endtask

  task play(input logic [1:0] t, input int n, input int d [8], input logic [1:0] exp_score, input string name);
    int f0;
    f0 = fin_cnt;
    start_round(t);
    for (int i = 0; i < n; i++) press(10'd1 << d[i]);
    total += 4;
    if (fin_cnt !== f0 + 1) $display("FAIL %s_finish: got %0d pulses expected 1", name, fin_cnt - f0);
    else pass_cnt++;
    if (bus.score !== exp_score) $display("FAIL %s_score: got %0d expected %0d", name, bus.score, exp_score);
    else pass_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL %s_busy: got %b expected 0", name, bus.busy);
    else pass_cnt++;
    if (bus.idx !== 4'(n)) $display("FAIL %s_idx: got %0d expected %0d", name, bus.idx, n);
    else pass_cnt++;
  endtask

  task test_reset;
    bus.sw = 10'h3FF;
    bus.start = 1'b1;
    bus.testcase = 2'd0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total += 4;
    if (bus.score !== 2'd0) $display("FAIL reset_score: got %0d expected 0", bus.score); else pass_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else pass_cnt++;
    if (bus.compare_finish !== 1'b0) $display("FAIL reset_finish: got %b expected 0", bus.compare_finish); else pass_cnt++;
    if (bus.idx !== 4'd0) $display("FAIL reset_idx: got %0d expected 0", bus.idx); else pass_cnt++;
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    bus.sw = '0;
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    total += 2;
    if (bus.busy !== 1'b0) $display("FAIL post_reset_busy: got %b expected 0", bus.busy); else pass_cnt++;
    if (fin_cnt !== 0) $display("FAIL post_reset_finish: got %0d expected 0", fin_cnt); else pass_cnt++;
  endtask

  task test_perfect;
    play(2'd3, 3, '{9, 2, 7, 0, 0, 0, 0, 0}, 2'd3, "perfect");
  endtask

  task test_errors;
    play(2'd2, 5, '{0, 4, 5, 3, 2, 0, 0, 0}, 2'd2, "one_err");
    play(2'd2, 5, '{0, 6, 1, 3, 8, 0, 0, 0}, 2'd1, "two_err");
  endtask

  task test_abort;
    play(2'd1, 3, '{3, 3, 3, 0, 0, 0, 0, 0}, 2'd0, "abort");
    bus.sw = 10'h002;
    repeat (8) @(negedge clk);
    bus.sw = '0;
    @(negedge clk);
    total += 2;
    if (bus.idx !== 4'd3) $display("FAIL idle_press_idx: got %0d expected 3", bus.idx); else pass_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL idle_press_busy: got %b expected 0", bus.busy); else pass_cnt++;
  endtask

  task test_timeout;
    int f0;
    f0 = fin_cnt;
    start_round(2'd3);
    repeat (8) @(negedge clk);
    total++;
    if (bus.idx !== 4'd0) $display("FAIL timeout_early: got %0d expected 0", bus.idx); else pass_cnt++;
    @(negedge clk);
    total++;
    if (bus.idx !== 4'd1) $display("FAIL timeout_idx: got %0d expected 1", bus.idx); else pass_cnt++;
    press(10'h014);
    press(10'h080);
    total += 2;
    if (bus.score !== 2'd1) $display("FAIL timeout_score: got %0d expected 1", bus.score); else pass_cnt++;
    if (fin_cnt !== f0 + 1) $display("FAIL timeout_finish: got %0d pulses expected 1", fin_cnt - f0); else pass_cnt++;
  endtask

  task test_start_midround;
    int f0;
    f0 = fin_cnt;
    start_round(2'd3);
    press(10'h200);
    @(negedge clk);
    bus.start = 1'b1;
    bus.testcase = 2'd2;
    @(negedge clk);
    bus.start = 1'b0;
    total += 2;
    if (bus.idx !== 4'd1) $display("FAIL restart_idx: got %0d expected 1", bus.idx); else pass_cnt++;
    if (bus.busy !== 1'b1) $display("FAIL restart_busy: got %b expected 1", bus.busy); else pass_cnt++;
    press(10'h004);
    press(10'h080);
    total += 3;
    if (bus.score !== 2'd3) $display("FAIL latched_score: got %0d expected 3", bus.score); else pass_cnt++;
    if (bus.idx !== 4'd3) $display("FAIL latched_idx: got %0d expected 3", bus.idx); else pass_cnt++;
    if (fin_cnt !== f0 + 1) $display("FAIL latched_finish: got %0d pulses expected 1", fin_cnt - f0); else pass_cnt++;
  endtask

  task test_tc0;
    @(negedge clk);
    bus.testcase = 2'd0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    total += 2;
    if (bus.busy !== 1'b0) $display("FAIL tc0_busy: got %b expected 0", bus.busy); else pass_cnt++;
    if (bus.idx !== 4'd3) $display("FAIL tc0_idx: got %0d expected 3", bus.idx); else pass_cnt++;
  endtask

  task test_reset_midround;
    int f0;
    f0 = fin_cnt;
    start_round(2'd3);
    press(10'h200);
    reset_n = 1'b0;
    #1;
    total += 3;
    if (bus.busy !== 1'b0) $display("FAIL midreset_busy: got %b expected 0", bus.busy); else pass_cnt++;
    if (bus.score !== 2'd0) $display("FAIL midreset_score: got %0d expected 0", bus.score); else pass_cnt++;
    if (bus.idx !== 4'd0) $display("FAIL midreset_idx: got %0d expected 0", bus.idx); else pass_cnt++;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    total += 2;
    if (fin_cnt !== f0) $display("FAIL midreset_finish: got %0d pulses expected 0", fin_cnt - f0); else pass_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL midreset_idle: got %b expected 0", bus.busy); else pass_cnt++;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.testcase = 2'd0;
    bus.sw = '0;
    test_reset;
    test_perfect;
    test_errors;
    test_abort;
    test_timeout;
    test_start_midround;
    test_tc0;
    test_reset_midround;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
